// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, feeding the 16-bit ALU.
// Operands are bypassed from MEM/WB at capture, snooped while held, and forwarded from EX/MEM at output.
module id_ex_operand_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [IMM_W-1:0]  id_imm,
  input  logic              id_use_imm,
  input  logic [2:0]        id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic              ex_ready,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd_addr,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_reg_write
);

  localparam logic [2:0] CTRL_SHL = 3'b011;
  localparam logic [2:0] CTRL_SHR = 3'b100;

  logic              valid_reg;
  logic              valid_next;
  logic [REG_AW-1:0] rd_addr_reg;
  logic [IMM_W-1:0]  imm_reg;
  logic              use_imm_reg;
  logic [2:0]        alu_ctrl_reg;
  logic              reg_write_reg;

  logic              capture;
  logic              capture_en;

  // Index 0 carries rs, index 1 carries rt.
  logic [1:0][REG_AW-1:0] id_src_addr;
  logic [1:0][DATA_W-1:0] id_src_data;
  logic [1:0][REG_AW-1:0] src_addr_reg;
  logic [1:0][DATA_W-1:0] src_data_reg;
  logic [1:0][DATA_W-1:0] src_fwd;

  logic [DATA_W-1:0] imm_ext;

  assign in_ready   = !valid_reg || ex_ready;
  assign capture    = in_valid && in_ready;
  assign capture_en = capture && !flush;

  assign id_src_addr = {id_rt_addr, id_rs_addr};
  assign id_src_data = {id_rt_data, id_rs_data};

  always_comb begin
    valid_next = valid_reg;
    if (flush) begin
      valid_next = 1'b0;
    end else if (capture) begin
      valid_next = 1'b1;
    end else if (ex_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg     <= 1'b0;
      rd_addr_reg   <= '0;
      imm_reg       <= '0;
      use_imm_reg   <= 1'b0;
      alu_ctrl_reg  <= 3'b000;
      reg_write_reg <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      if (flush) begin
        reg_write_reg <= 1'b0;
      end else if (capture) begin
        rd_addr_reg   <= id_rd_addr;
        imm_reg       <= id_imm;
        use_imm_reg   <= id_use_imm;
        alu_ctrl_reg  <= id_alu_ctrl;
        reg_write_reg <= id_reg_write;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      logic wb_hit_id;
      logic wb_hit_held;
      logic exm_hit_held;

      assign wb_hit_id    = wb_reg_write && (wb_rd_addr == id_src_addr[gi]) &&
                            (id_src_addr[gi] != '0);
      assign wb_hit_held  = wb_reg_write && (wb_rd_addr == src_addr_reg[gi]) &&
                            (src_addr_reg[gi] != '0);
      assign exm_hit_held = exm_reg_write && (exm_rd_addr == src_addr_reg[gi]) &&
                            (src_addr_reg[gi] != '0);

      // r0 is latched as zero, so neither snoop nor forwarding can ever disturb it.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          src_addr_reg[gi] <= '0;
          src_data_reg[gi] <= '0;
        end else if (capture_en) begin
          src_addr_reg[gi] <= id_src_addr[gi];
          if (id_src_addr[gi] == '0) begin
            src_data_reg[gi] <= '0;
          end else if (wb_hit_id) begin
            src_data_reg[gi] <= wb_data;
          end else begin
            src_data_reg[gi] <= id_src_data[gi];
          end
        end else if (valid_reg && wb_hit_held) begin
          src_data_reg[gi] <= wb_data;
        end
      end

      assign src_fwd[gi] = exm_hit_held ? exm_result : src_data_reg[gi];
    end
  endgenerate

  // Shift amounts are unsigned; every other immediate is signed.
  always_comb begin
    imm_ext = {{(DATA_W-IMM_W){imm_reg[IMM_W-1]}}, imm_reg};
    if (alu_ctrl_reg == CTRL_SHL || alu_ctrl_reg == CTRL_SHR) begin
      imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm_reg};
    end
  end

  assign out_valid     = valid_reg;
  assign alu_a         = src_fwd[0];
  assign alu_b         = use_imm_reg ? imm_ext : src_fwd[1];
  assign out_rt_data   = src_fwd[1];
  assign alu_ctrl      = alu_ctrl_reg;
  assign out_rd_addr   = rd_addr_reg;
  assign out_reg_write = reg_write_reg && valid_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage.
// Inputs change 1ns after the rising edge; outputs are compared 1ns later.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [15:0] id_rs_data, id_rt_data;
  logic [5:0]  id_imm;
  logic        id_use_imm;
  logic [2:0]  id_alu_ctrl;
  logic        id_reg_write;
  logic        flush;
  logic        ex_ready;
  logic        exm_reg_write;
  logic [2:0]  exm_rd_addr;
  logic [15:0] exm_result;
  logic        wb_reg_write;
  logic [2:0]  wb_rd_addr;
  logic [15:0] wb_data;
  logic        out_valid;
  logic [15:0] alu_a, alu_b, out_rt_data;
  logic [2:0]  alu_ctrl;
  logic [2:0]  out_rd_addr;
  logic        out_reg_write;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_alu_ctrl(id_alu_ctrl), .id_reg_write(id_reg_write),
    .flush(flush), .ex_ready(ex_ready),
    .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .out_rt_data(out_rt_data), .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_bypass;
    exm_reg_write = 1'b0; exm_rd_addr = 3'd0; exm_result = 16'h0000;
    wb_reg_write  = 1'b0; wb_rd_addr  = 3'd0; wb_data    = 16'h0000;
  endtask

  task automatic drive_id(input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                          input logic [15:0] rsd, input logic [15:0] rtd, input logic [5:0] imm,
                          input logic use_imm, input logic [2:0] ctrl, input logic rw);
    in_valid = 1'b1;
    id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_use_imm = use_imm; id_alu_ctrl = ctrl; id_reg_write = rw;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    quiet_bypass();
    drive_id(3'd2, 3'd3, 3'd1, 16'h1234, 16'h5678, 6'h3F, 1'b0, 3'b010, 1'b1);
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (alu_a !== 16'h0000) begin errors++; $display("FAIL reset_alu_a got=%h exp=0000", alu_a); end
    checks++; if (alu_b !== 16'h0000) begin errors++; $display("FAIL reset_alu_b got=%h exp=0000", alu_b); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (alu_ctrl !== 3'b000 || out_reg_write !== 1'b0 || out_rd_addr !== 3'd0 || out_rt_data !== 16'h0000) begin
      errors++; $display("FAIL reset_fields got ctrl=%b rw=%b rd=%0d rt=%h exp all zero", alu_ctrl, out_reg_write, out_rd_addr, out_rt_data);
    end
    $display("reset: out_valid=%b alu_a=%h alu_b=%h in_ready=%b", out_valid, alu_a, alu_b, in_ready);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back;
    // add r1 = r2 + r3
    drive_id(3'd2, 3'd3, 3'd1, 16'h0002, 16'h0003, 6'h00, 1'b0, 3'b000, 1'b1);
    tick();
    // sub r4 = r1 - r2; register file still holds a stale r1
    drive_id(3'd1, 3'd2, 3'd4, 16'h9999, 16'h0002, 6'h00, 1'b0, 3'b001, 1'b1);
    #1;
    checks++; if (alu_a !== 16'h0002 || alu_b !== 16'h0003) begin errors++; $display("FAIL b2b_add_ops got a=%h b=%h exp a=0002 b=0003", alu_a, alu_b); end
    checks++; if (out_valid !== 1'b1 || out_reg_write !== 1'b1 || out_rd_addr !== 3'd1) begin
      errors++; $display("FAIL b2b_add_ctl got v=%b rw=%b rd=%0d exp v=1 rw=1 rd=1", out_valid, out_reg_write, out_rd_addr);
    end
    $display("b2b add: alu_a=%h alu_b=%h rd=%0d", alu_a, alu_b, out_rd_addr);
    tick();
    in_valid = 1'b0;
    exm_reg_write = 1'b1; exm_rd_addr = 3'd1; exm_result = 16'h0005;
    #1;
    checks++; if (alu_a !== 16'h0005) begin errors++; $display("FAIL b2b_fwd_alu_a got=%h exp=0005", alu_a); end
    checks++; if (alu_b !== 16'h0002 || alu_ctrl !== 3'b001 || out_rd_addr !== 3'd4) begin
      errors++; $display("FAIL b2b_sub_fields got b=%h ctrl=%b rd=%0d exp b=0002 ctrl=001 rd=4", alu_b, alu_ctrl, out_rd_addr);
    end
    $display("b2b sub: alu_a=%h alu_b=%h ctrl=%b", alu_a, alu_b, alu_ctrl);
    quiet_bypass();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    $display("b2b drain: out_valid=%b", out_valid);
  endtask

  task automatic test_priority;
    drive_id(3'd2, 3'd0, 3'd5, 16'h0AAA, 16'h7777, 6'h00, 1'b0, 3'b000, 1'b1);
    tick();
    in_valid = 1'b0;
    exm_reg_write = 1'b1; exm_rd_addr = 3'd2; exm_result = 16'h1111;
    wb_reg_write  = 1'b1; wb_rd_addr  = 3'd2; wb_data    = 16'h2222;
    #1;
    checks++; if (alu_a !== 16'h1111) begin errors++; $display("FAIL prio_exm_over_wb got=%h exp=1111", alu_a); end
    checks++; if (alu_b !== 16'h0000 || out_rt_data !== 16'h0000) begin
      errors++; $display("FAIL prio_rt_r0 got b=%h rt=%h exp 0000", alu_b, out_rt_data);
    end
    exm_reg_write = 1'b0;
    #1;
    checks++; if (alu_a !== 16'h0AAA) begin errors++; $display("FAIL prio_held_no_exm got=%h exp=0aaa", alu_a); end
    $display("priority: rs held=%h", alu_a);
    // everything targets r0: must read zero
    drive_id(3'd0, 3'd0, 3'd6, 16'h3333, 16'h4444, 6'h00, 1'b0, 3'b000, 1'b1);
    exm_reg_write = 1'b1; exm_rd_addr = 3'd0; exm_result = 16'h1111;
    wb_reg_write  = 1'b1; wb_rd_addr  = 3'd0; wb_data    = 16'h2222;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (alu_a !== 16'h0000 || alu_b !== 16'h0000) begin
      errors++; $display("FAIL prio_r0 got a=%h b=%h exp 0000", alu_a, alu_b);
    end
    $display("priority r0: alu_a=%h alu_b=%h", alu_a, alu_b);
    quiet_bypass();
    tick();
  endtask

  task automatic test_capture_bypass;
    drive_id(3'd3, 3'd5, 3'd2, 16'h0001, 16'h0055, 6'h00, 1'b0, 3'b010, 1'b1);
    wb_reg_write = 1'b1; wb_rd_addr = 3'd3; wb_data = 16'h4242;
    tick();
    in_valid = 1'b0; quiet_bypass();
    #1;
    checks++; if (alu_a !== 16'h4242 || alu_b !== 16'h0055) begin
      errors++; $display("FAIL cap_bypass got a=%h b=%h exp a=4242 b=0055", alu_a, alu_b);
    end
    $display("capture bypass: alu_a=%h alu_b=%h", alu_a, alu_b);
    tick();
  endtask

  task automatic test_stall_snoop;
    drive_id(3'd1, 3'd3, 3'd6, 16'h0010, 16'h0033, 6'h00, 1'b0, 3'b000, 1'b1);
    tick();
    // a second instruction waits in ID for the whole stall
    drive_id(3'd2, 3'd4, 3'd7, 16'h0101, 16'h0202, 6'h00, 1'b0, 3'b101, 1'b1);
    ex_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        wb_reg_write = 1'b1; wb_rd_addr = 3'd3; wb_data = 16'hBEEF;
      end else begin
        quiet_bypass();
      end
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
      $display("stall cycle %0d: in_ready=%b alu_b=%h", c, in_ready, alu_b);
      tick();
    end
    quiet_bypass();
    ex_ready = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (alu_b !== 16'hBEEF) begin errors++; $display("FAIL stall_snoop_alu_b got=%h exp=beef", alu_b); end
    checks++; if (out_valid !== 1'b1 || out_rd_addr !== 3'd6 || alu_a !== 16'h0010) begin
      errors++; $display("FAIL stall_held got v=%b rd=%0d a=%h exp v=1 rd=6 a=0010", out_valid, out_rd_addr, alu_a);
    end
    $display("stall release: alu_b=%h rd=%0d", alu_b, out_rd_addr);
    tick();
  endtask

  task automatic test_immediate;
    drive_id(3'd1, 3'd2, 3'd3, 16'h0000, 16'h1234, 6'h3E, 1'b1, 3'b000, 1'b1);
    tick();
    drive_id(3'd1, 3'd2, 3'd3, 16'h0000, 16'h1234, 6'h3E, 1'b1, 3'b011, 1'b1);
    #1;
    checks++; if (alu_b !== 16'hFFFE) begin errors++; $display("FAIL imm_sext got=%h exp=fffe", alu_b); end
    checks++; if (out_rt_data !== 16'h1234) begin errors++; $display("FAIL imm_rt_data got=%h exp=1234", out_rt_data); end
    $display("imm add: alu_b=%h rt=%h", alu_b, out_rt_data);
    tick();
    drive_id(3'd1, 3'd2, 3'd3, 16'h0000, 16'h1234, 6'h25, 1'b1, 3'b100, 1'b1);
    #1;
    checks++; if (alu_b !== 16'h003E) begin errors++; $display("FAIL imm_zext_shl got=%h exp=003e", alu_b); end
    $display("imm shl: alu_b=%h", alu_b);
    tick();
    drive_id(3'd1, 3'd2, 3'd3, 16'h0000, 16'h1234, 6'h25, 1'b1, 3'b001, 1'b1);
    #1;
    checks++; if (alu_b !== 16'h0025) begin errors++; $display("FAIL imm_zext_shr got=%h exp=0025", alu_b); end
    $display("imm shr: alu_b=%h", alu_b);
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (alu_b !== 16'hFFE5) begin errors++; $display("FAIL imm_sext_sub got=%h exp=ffe5", alu_b); end
    $display("imm sub: alu_b=%h", alu_b);
    tick();
  endtask

  task automatic test_flush;
    drive_id(3'd1, 3'd2, 3'd5, 16'h0001, 16'h0002, 6'h00, 1'b0, 3'b000, 1'b1);
    tick();
    drive_id(3'd3, 3'd4, 3'd7, 16'h0003, 16'h0004, 6'h00, 1'b0, 3'b010, 1'b1);
    ex_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_reg_write !== 1'b0) begin
      errors++; $display("FAIL flush_kill got v=%b rw=%b exp v=0 rw=0", out_valid, out_reg_write);
    end
    checks++; if (out_rd_addr !== 3'd5 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_no_capture got rd=%0d in_ready=%b exp rd=5 in_ready=1", out_rd_addr, in_ready);
    end
    $display("flush: out_valid=%b reg_write=%b rd=%0d", out_valid, out_reg_write, out_rd_addr);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_stays_empty got=%b exp=0", out_valid); end
    ex_ready = 1'b1;
  endtask

  task automatic test_reset_midstall;
    drive_id(3'd2, 3'd3, 3'd4, 16'h00AA, 16'h00BB, 6'h00, 1'b0, 3'b000, 1'b1);
    tick();
    ex_ready = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || alu_a !== 16'h0000 || out_reg_write !== 1'b0) begin
      errors++; $display("FAIL reset_midstall got v=%b a=%h rw=%b exp 0", out_valid, alu_a, out_reg_write);
    end
    $display("reset mid-stall: out_valid=%b alu_a=%h", out_valid, alu_a);
    ex_ready = 1'b1;
    tick();
  endtask

  initial begin
    in_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1; rst_n = 1'b0;
    id_rs_addr = 3'd0; id_rt_addr = 3'd0; id_rd_addr = 3'd0;
    id_rs_data = 16'h0000; id_rt_data = 16'h0000; id_imm = 6'h00;
    id_use_imm = 1'b0; id_alu_ctrl = 3'b000; id_reg_write = 1'b0;
    quiet_bypass();
    test_reset();
    test_back_to_back();
    test_priority();
    test_capture_bypass();
    test_stall_snoop();
    test_immediate();
    test_flush();
    test_reset_midstall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
